// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
//
// Shared definitions for the memory read-port arbiter:
//   - default SIZE / NREQ / TIMEOUT values used by the top, the interface and
//     the round-robin sub-module
//   - the FSM state encoding (IDLE, ACCESS, RESP)
//   - idx_width(): width of a binary requester index (never less than 1 bit)
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int DEFAULT_SIZE    = 16;
    localparam int DEFAULT_NREQ    = 4;
    localparam int DEFAULT_TIMEOUT = 15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    // A single requester still needs a 1-bit index so the pointer port exists.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
//
// Bundles the requester-side handshake and the memory read-port bus of the
// arbiter. clk / rst are not part of the bundle.
//
// Signals:
//   req          requester read request, one bit per requester (level)
//   req_addr     requester i address in bits [i*SIZE +: SIZE]
//   gnt          one-hot grant of the requester being served
//   done         one-cycle completion pulse to the served requester
//   err          valid with done; 1 = access aborted by the watchdog
//   rd_data      read data, valid with done, held until the next completion
//   mem_ready    memory data-valid handshake
//   mem_data_bus memory read data
//   mem_addr_bus address presented to memory
//   mem_cs       memory chip select
//   mem_read     memory read strobe
//
// Modports:
//   slave  - the arbiter's view (drives gnt/done/err/rd_data and memory controls)
//   master - the environment's view (requesters plus memory device)
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int SIZE = DEFAULT_SIZE,
    parameter int NREQ = DEFAULT_NREQ
);

    logic [NREQ-1:0]      req;
    logic [NREQ*SIZE-1:0] req_addr;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      done;
    logic                 err;
    logic [SIZE-1:0]      rd_data;
    logic                 mem_ready;
    logic [SIZE-1:0]      mem_data_bus;
    logic [SIZE-1:0]      mem_addr_bus;
    logic                 mem_cs;
    logic                 mem_read;

    modport slave (
        input  req,
        input  req_addr,
        input  mem_ready,
        input  mem_data_bus,
        output gnt,
        output done,
        output err,
        output rd_data,
        output mem_addr_bus,
        output mem_cs,
        output mem_read
    );

    modport master (
        output req,
        output req_addr,
        output mem_ready,
        output mem_data_bus,
        input  gnt,
        input  done,
        input  err,
        input  rd_data,
        input  mem_addr_bus,
        input  mem_cs,
        input  mem_read
    );

endinterface

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//
// Purely combinational round-robin pick. Starting just after the last granted
// index (ptr) it scans upward with wrap-around and selects the first asserted
// request.
//
// Ports:
//   req    in  NREQ  request vector
//   ptr    in  IDXW  index of the last granted requester
//   grant  out NREQ  one-hot selection (all zero when no request)
//   index  out IDXW  binary form of grant
//   valid  out 1     at least one request is asserted
// -----------------------------------------------------------------------------
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ = DEFAULT_NREQ,
    parameter int IDXW = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDXW-1:0] index,
    output logic            valid
);

    // Distance k = 1 is the requester right after the pointer, k = NREQ is
    // the pointer itself, so the last-served port ranks lowest. The first
    // hit in distance order wins; valid blocks any later hit.
    always_comb begin
        grant = '0;
        index = '0;
        valid = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!valid && req[i] && (i == ((int'(ptr) + k) % NREQ))) begin
                    valid    = 1'b1;
                    grant[i] = 1'b1;
                    index    = IDXW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one memory read port between NREQ requesters using round-robin
// arbitration. Each access runs IDLE -> ACCESS -> RESP: the winner is granted
// and its address driven with mem_cs/mem_read in ACCESS until mem_ready, then
// RESP pulses done for one cycle with the captured read data.
//
// Optional feature (macro ARB_TIMEOUT_EN): a watchdog aborts an ACCESS that
// has waited TIMEOUT cycles without mem_ready, completing with err=1 and
// rd_data=0. Without the macro ACCESS waits indefinitely and err is 0.
//
// Parameters:
//   SIZE     address / data width
//   NREQ     number of requesters (2..8)
//   TIMEOUT  ACCESS cycles before abort (only used with ARB_TIMEOUT_EN)
//
// Ports:
//   clk  in  rising-edge clock
//   rst  in  synchronous active-high reset
//   bus  mem_port_arbiter_if.slave - requester handshake and memory port
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int SIZE    = DEFAULT_SIZE,
    parameter int NREQ    = DEFAULT_NREQ,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    localparam int IDXW = idx_width(NREQ);

    arb_state_t      state_q, state_n;
    logic [NREQ-1:0] gnt_q, gnt_n;
    logic [NREQ-1:0] done_q, done_n;
    logic [SIZE-1:0] rd_data_q, rd_data_n;
    logic [SIZE-1:0] addr_q, addr_n;
    logic            access_q, access_n;
    logic [IDXW-1:0] ptr_q, ptr_n;

    logic [NREQ-1:0] arb_grant;
    logic [IDXW-1:0] arb_index;
    logic            arb_valid;
    logic [SIZE-1:0] sel_addr;

    logic            timeout_hit;

`ifdef ARB_TIMEOUT_EN
    localparam int CNTW = $clog2(TIMEOUT + 1);

    logic [CNTW-1:0] cnt_q, cnt_n;
    logic [CNTW-1:0] cnt_inc;
    logic            err_q, err_n;

    // The abort fires on the edge at which the wait count would reach TIMEOUT.
    assign cnt_inc     = cnt_q + CNTW'(1);
    assign timeout_hit = (cnt_inc == CNTW'(TIMEOUT));
    assign bus.err     = err_q;
`else
    assign timeout_hit = 1'b0;
    assign bus.err     = 1'b0;
`endif

    rr_arbiter #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr (
        .req   (bus.req),
        .ptr   (ptr_q),
        .grant (arb_grant),
        .index (arb_index),
        .valid (arb_valid)
    );

    // The grant is one-hot, so OR-ing the selected slices gives the winner's
    // address without a variable part-select.
    always_comb begin
        sel_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_grant[i]) begin
                sel_addr = sel_addr | bus.req_addr[i*SIZE +: SIZE];
            end
        end
    end

    // Next-state and next-output logic. Every register defaults to holding its
    // value except done, which is a single-cycle pulse. mem_ready only matters
    // in ACCESS; requests only matter in IDLE.
    always_comb begin
        state_n   = state_q;
        gnt_n     = gnt_q;
        done_n    = '0;
        rd_data_n = rd_data_q;
        addr_n    = addr_q;
        access_n  = access_q;
        ptr_n     = ptr_q;
`ifdef ARB_TIMEOUT_EN
        cnt_n     = cnt_q;
        err_n     = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    gnt_n    = arb_grant;
                    addr_n   = sel_addr;
                    access_n = 1'b1;
                    ptr_n    = arb_index;
                    state_n  = ACCESS;
`ifdef ARB_TIMEOUT_EN
                    cnt_n    = '0;
`endif
                end
            end
            ACCESS: begin
                // mem_ready takes priority so a reply on the abort edge is kept.
                if (bus.mem_ready) begin
                    rd_data_n = bus.mem_data_bus;
                    access_n  = 1'b0;
                    done_n    = gnt_q;
                    state_n   = RESP;
`ifdef ARB_TIMEOUT_EN
                    err_n     = 1'b0;
`endif
                end else if (timeout_hit) begin
                    rd_data_n = '0;
                    access_n  = 1'b0;
                    done_n    = gnt_q;
                    state_n   = RESP;
`ifdef ARB_TIMEOUT_EN
                    err_n     = 1'b1;
`endif
                end else begin
`ifdef ARB_TIMEOUT_EN
                    cnt_n     = cnt_inc;
`endif
                end
            end
            RESP: begin
                gnt_n   = '0;
                state_n = IDLE;
            end
            default: begin
                gnt_n    = '0;
                access_n = 1'b0;
                state_n  = IDLE;
            end
        endcase
    end

    // State and output registers. The pointer resets to the last index so
    // requester 0 is first in line after reset; reset also drops any access
    // in flight without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            done_q    <= '0;
            rd_data_q <= '0;
            addr_q    <= '0;
            access_q  <= 1'b0;
            ptr_q     <= IDXW'(NREQ - 1);
`ifdef ARB_TIMEOUT_EN
            cnt_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_n;
            gnt_q     <= gnt_n;
            done_q    <= done_n;
            rd_data_q <= rd_data_n;
            addr_q    <= addr_n;
            access_q  <= access_n;
            ptr_q     <= ptr_n;
`ifdef ARB_TIMEOUT_EN
            cnt_q     <= cnt_n;
            err_q     <= err_n;
`endif
        end
    end

    assign bus.gnt          = gnt_q;
    assign bus.done         = done_q;
    assign bus.rd_data      = rd_data_q;
    assign bus.mem_addr_bus = addr_q;
    assign bus.mem_cs       = access_q;
    assign bus.mem_read     = access_q;

endmodule
